// File: rtl/inst_encode_loader_pkg.sv
// Shared opcodes, instruction formats, loader FSM states and the command struct
// used by the encoder/loader and its field packer.
package inst_encode_loader_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REGREG = 7'b0110011;
  localparam logic [6:0] OP_REGIMM = 7'b0010011;

  typedef enum logic [2:0] {RTYPE, ITYPE, STYPE, BTYPE, UTYPE, JTYPE, NOFMT} fmt_e;

  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, FULL} state_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } cmd_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_REGREG:                    f = RTYPE;
      OP_LOAD, OP_JALR, OP_REGIMM:  f = ITYPE;
      OP_STORE:                     f = STYPE;
      OP_BRANCH:                    f = BTYPE;
      OP_LUI, OP_AUIPC:             f = UTYPE;
      OP_JAL:                       f = JTYPE;
      default:                      f = NOFMT;
    endcase
    return f;
  endfunction

  // True when v is representable as a signed value of (sh+1) bits.
  function automatic logic fits(input logic [31:0] v, input int unsigned sh);
    logic [31:0] t;
    t = 32'($signed(v) >>> sh);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/inst_encode_loader_packer.sv
// Combinational RV32I field packer: command fields -> instruction word, legal, range_ok.
// Immediate range checking exists only when ENC_IMM_CHECK_EN is defined; otherwise range_ok is 1.
module inst_field_packer
  import inst_encode_loader_pkg::*;
(
  input  cmd_t        cmd,
  output logic [31:0] word,
  output logic        legal,
  output logic        range_ok
);

  fmt_e fmt;
  logic shift;

  assign fmt   = fmt_of(cmd.op);
  assign shift = (cmd.op == OP_REGIMM) && (cmd.fn3[1:0] == 2'b01);
  assign legal = (fmt != NOFMT);

  always_comb begin
    word = '0;
    case (fmt)
      RTYPE: word = {cmd.fn7, cmd.rs2, cmd.rs1, cmd.fn3, cmd.rd, cmd.op};
      ITYPE: word = shift ? {cmd.fn7, cmd.imm[4:0], cmd.rs1, cmd.fn3, cmd.rd, cmd.op}
                          : {cmd.imm[11:0], cmd.rs1, cmd.fn3, cmd.rd, cmd.op};
      STYPE: word = {cmd.imm[11:5], cmd.rs2, cmd.rs1, cmd.fn3, cmd.imm[4:0], cmd.op};
      BTYPE: word = {cmd.imm[12], cmd.imm[10:5], cmd.rs2, cmd.rs1, cmd.fn3,
                     cmd.imm[4:1], cmd.imm[11], cmd.op};
      UTYPE: word = {cmd.imm[31:12], cmd.rd, cmd.op};
      JTYPE: word = {cmd.imm[20], cmd.imm[10:1], cmd.imm[11], cmd.imm[19:12], cmd.rd, cmd.op};
      default: word = '0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      ITYPE: range_ok = shift ? (cmd.imm[31:5] == '0) : fits(cmd.imm, 11);
      STYPE: range_ok = fits(cmd.imm, 11);
      BTYPE: range_ok = fits(cmd.imm, 12) && !cmd.imm[0];
      UTYPE: range_ok = (cmd.imm[11:0] == '0);
      JTYPE: range_ok = fits(cmd.imm, 20) && !cmd.imm[0];
      default: range_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = cmd.imm[0];
  assign range_ok    = 1'b1;
`endif

endmodule

// File: rtl/inst_encode_loader.sv
// RV32I encoder/loader: one command per 2 cycles, imem write 1 cycle after handshake; cmd_ready only in RUN.
// Optional ENC_IMM_CHECK_EN rejects out-of-range immediates into err_range.
module inst_encode_loader
  import inst_encode_loader_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_op,
  input  logic [2:0]        cmd_fn3,
  input  logic [6:0]        cmd_fn7,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_full,
  output logic              err_range
);

  // Count value of the final free slot; reaching it while writing means memory is full.
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_e      state, state_nxt;
  cmd_t        cmd;
  logic [31:0] word;
  logic        legal, range_ok;
  logic        accept, good, clear, last_q;

  assign cmd = {cmd_op, cmd_fn3, cmd_fn7, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm};

  inst_field_packer u_packer (
    .cmd      (cmd),
    .word     (word),
    .legal    (legal),
    .range_ok (range_ok)
  );

  assign accept    = cmd_valid && (state == RUN);
  assign good      = legal && range_ok;
  assign clear     = start && ((state == IDLE) || (state == FULL));
  assign cmd_ready = (state == RUN);
  assign imem_we   = (state == WRITE);
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (good)          state_nxt = WRITE;
          else if (cmd_last) state_nxt = DONE;
        end
      end
      WRITE: begin
        if (last_q)                        state_nxt = DONE;
        else if (word_count == LAST_CNT)   state_nxt = FULL;
        else                               state_nxt = RUN;
      end
      DONE:  state_nxt = IDLE;
      FULL:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr   <= BASE_ADDR;
      imem_wdata  <= '0;
      word_count  <= '0;
      last_q      <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      if (clear) begin
        imem_addr   <= BASE_ADDR;
        word_count  <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
      end
      if (accept && good) begin
        imem_wdata <= word;
        last_q     <= cmd_last;
      end
      if (accept && !legal) err_illegal <= 1'b1;
      if (state == WRITE) begin
        imem_addr  <= imem_addr + 1'b1;
        word_count <= word_count + 1'b1;
        if (state_nxt == FULL) err_full <= 1'b1;
      end
    end
  end

`ifdef ENC_IMM_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_range <= 1'b0;
    else if (clear)                       err_range <= 1'b0;
    else if (accept && legal && !range_ok) err_range <= 1'b1;
  end
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader (ADDR_W=2) with a write scoreboard checked by a negedge monitor.
module tb_inst_encode_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [6:0]        cmd_op = '0;
  logic [2:0]        cmd_fn3 = '0;
  logic [6:0]        cmd_fn7 = '0;
  logic [4:0]        cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0]       cmd_imm = '0;
  logic              cmd_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal, err_full, err_range;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              prev_we = 1'b0;

  inst_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fn3(cmd_fn3), .cmd_fn7(cmd_fn7),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .load_done(load_done), .word_count(word_count),
    .err_illegal(err_illegal), .err_full(err_full), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard; writes never back to back.
  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      check("no_back_to_back_we", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
      end
    end
    prev_we = (imem_we === 1'b1);
  end

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input logic wr,
                      input logic [31:0] word);
    int n = 0;
    cmd_op = op; cmd_fn3 = fn3; cmd_fn7 = fn7;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm = imm; cmd_last = last;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    if (wr) begin
      exp_q.push_back(exp_t'{exp_addr, word});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_last = 1'b0;
    @(negedge clk);
    check("we_one_cycle_after_handshake", 32'(imem_we), 32'(wr));
  endtask

  task automatic wait_done(input int exp_count);
    int n = 0;
    while (load_done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("word_count", 32'(word_count), 32'(exp_count));
    @(negedge clk);
    check("load_done_one_cycle", 32'(load_done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #20;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", {29'd0, err_illegal, err_full, err_range}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    start_session();
    send(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3);
    wait_done(1);

    // ADDI x1,x0,5 ; SW x2,8(x1)
    start_session();
    send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
    send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b1, 32'h0020A423);
    wait_done(2);

    // BEQ, JAL, LUI, LW: fills all four slots, last wins over full
    start_session();
    send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 1'b1, 32'hFE208EE3);
    send(7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b1, 32'h010000EF);
    send(7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
    send(7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd1, 1'b1, 1'b1, 32'hFFF12283);
    wait_done(4);
    check("no_full_when_last", 32'(err_full), 32'd0);

    // SRAI x1,x1,3 then an illegal opcode carrying last
    start_session();
    send(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 1'b1, 32'h4030D093);
    send(7'b0000000, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    wait_done(1);
    check("err_illegal_set", 32'(err_illegal), 32'd1);
    check("addr_after_illegal", 32'(imem_addr), 32'd1);

    // Overfill: four writes then FULL blocks the fifth command
    start_session();
    check("start_clears_illegal", 32'(err_illegal), 32'd0);
    check("start_clears_count", 32'(word_count), 32'd0);
    for (int i = 1; i <= 4; i++)
      send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0, 1'b1, 32'h00000093 | (32'(i) << 20));
    cmd_op = 7'b0010011; cmd_rd = 5'd1; cmd_imm = 32'd5; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("full_err_full", 32'(err_full), 32'd1);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_word_count", 32'(word_count), 32'd4);
    cmd_valid = 1'b0;
    start_session();
    check("restart_err_full", 32'(err_full), 32'd0);
    check("restart_addr", 32'(imem_addr), 32'd0);
    check("restart_count", 32'(word_count), 32'd0);

    // ADDI x1,x0,4096: out of 12-bit range
`ifdef ENC_IMM_CHECK_EN
    send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 1'b0, 32'd0);
    wait_done(0);
    check("err_range_set", 32'(err_range), 32'd1);
`else
    send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 1'b1, 32'h00000093);
    wait_done(1);
    check("err_range_tied", 32'(err_range), 32'd0);
`endif

    // Reset asserted while the write strobe is high
    start_session();
    send(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1, 32'h00700113);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(imem_addr), 32'd0);
    check("abort_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Sequential RISC-V RV32I instruction encoder and loader. It is the inverse of the ID-stage decoder.
- It accepts field-level instruction commands (opcode, fn3, fn7, rd, rs1, rs2, imm) over a valid/ready handshake.
- It packs each command into a 32-bit instruction word in the correct R/I/S/B/U/J format.
- It writes the words sequentially into the instruction-memory BRAM write port. Used for test-program loading and debug injection before CPU release.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session; clears the counter and error flags
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  7  opcode (JAL, JALR, Load, Store, Branch, LUI, AUIPC, RegReg, RegImm)
- cmd_fn3  in  3  funct3
- cmd_fn7  in  7  funct7 (RegReg; RegImm shifts)
- cmd_rd / cmd_rs1 / cmd_rs2  in  5 each  register indices
- cmd_imm  in  32  signed byte-offset immediate; for U-type, the value occupies [31:12]
- cmd_last  in  1  final command of the session
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is not IDLE
- load_done  out  1  one-cycle pulse at session end
- word_count  out  ADDR_W+1  words written this session
- err_illegal / err_full / err_range  out  1 each  sticky error flags

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cmd_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, load_done=0, word_count=0, all error flags=0.
- State IDLE:
  - cmd_ready=0.
  - On start: addr=BASE_ADDR, word_count=0, errors cleared, go to RUN.
- State RUN:
  - cmd_ready=1.
  - On handshake: register the encoded word and the last bit, go to WRITE.
  - An illegal opcode (not in the list above) is not written; err_illegal is set and the state stays RUN. If last is also set, go to DONE.
- State WRITE:
  - cmd_ready=0, imem_we=1 for exactly this one cycle, at the current addr.
  - Next cycle: addr+1 and word_count+1.
  - If last was set, go to DONE.
  - Else if the written addr was BASE_ADDR+2^ADDR_W-1, go to FULL.
  - Else go to RUN.
- State DONE: load_done=1 for one cycle, then IDLE.
- State FULL:
  - cmd_ready=0 and err_full=1.
  - Only start leaves this state (same effect as start in IDLE).
- start is ignored in RUN, WRITE and DONE.
- Throughput is one instruction per 2 cycles. Latency from handshake to imem_we is 1 cycle.
- Encoding formats (fields listed MSB to LSB):
  - R: fn7, rs2, rs1, fn3, rd, op.
  - I (Load, JALR, RegImm): imm[11:0], rs1, fn3, rd, op.
  - RegImm with fn3 001 or 101: fn7, imm[4:0], rs1, fn3, rd, op.
  - S: imm[11:5], rs2, rs1, fn3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], op.
  - U (LUI, AUIPC): imm[31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
- Fields unused by a format are ignored, e.g. fn3 for U/J and rs2 for I.
- Asserting rst_n low mid-write aborts the session immediately. No partial write is held.

Optional Feature:
- Macro: ENC_IMM_CHECK_EN.
- When defined, each accepted command's immediate is range-checked:
  - I/S: -2048..2047.
  - B: -4096..4094, and must be even.
  - J: -1048576..1048574, and must be even.
  - Shift amounts: 0..31.
  - U: imm[11:0] must be 0.
- A violating command is handled like an illegal opcode (not written), except that err_range is set instead of err_illegal.
- When not defined: immediates are silently truncated to the format fields and err_range is tied to 0.

Decomposition:
- Shared package/header: opcode constants (OP_JAL … OP_RegImm), format codes (RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE), state encodings.
- One combinational sub-module, inst_field_packer: takes the command fields and outputs word[31:0], legal, and range_ok.
- The FSM, address counter and flags stay in the top level.

Test Plan:
- start; ADD x3,x1,x2 (op 0110011, fn3 0, fn7 0) with last=1 -> imem_we at addr 0, wdata 0x002081B3, load_done pulse, word_count=1.
- ADDI x1,x0,5 then SW x2,8(x1) -> addr0 gets 0x00500093, addr1 gets 0x0020A423, and imem_we is never asserted on back-to-back cycles.
- BEQ x1,x2,imm=-4; JAL x1,imm=16; LUI x5,imm=0x12345000 -> 0xFE208EE3, 0x010000EF, 0x123452B7.
- SRAI x1,x1,3 (fn7 0100000) -> 0x4030D093; opcode 0000000 -> no write, err_illegal=1, addr unchanged.
- ADDR_W=2: feed 5 commands -> 4 writes, then FULL with err_full=1 and cmd_ready=0; start -> flags cleared, addr=0.
- With ENC_IMM_CHECK_EN: ADDI imm=4096 -> err_range=1 and no write. Without it -> word written with imm field 0x000.
